// File: rtl/keypad_encoder.sv
// Decimal keypad front end: synchronise, debounce and BCD-encode key lines into a
// single active-low load pulse per press. Optional macro: KEYPAD_MULTIKEY_REJECT_EN.
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOAD_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] keys,
  input  logic       inhibit,
  output logic [3:0] data,
  output logic       loadn,
  output logic       busy,
  output logic       reject
);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE     = 2'd1;
  localparam logic [1:0] ST_EMIT         = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  localparam int CNT_TOP = (DEBOUNCE_CYCLES > LOAD_CYCLES) ? DEBOUNCE_CYCLES : LOAD_CYCLES;
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [9:0]    keys_meta;
  logic [9:0]    keys_s;
  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [9:0]    snap;
  logic [9:0]    snap_n;
  logic [3:0]    data_n;
  logic          loadn_n;
  logic          busy_n;

  // Lowest set index wins, so a multi-hot snapshot still encodes deterministically.
  function automatic logic [3:0] encode(input logic [9:0] k);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (k[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      keys_meta <= '0;
      keys_s    <= '0;
    end else begin
      keys_meta <= keys;
      keys_s    <= keys_meta;
    end
  end

`ifdef KEYPAD_MULTIKEY_REJECT_EN
  logic snap_multi;
  logic reject_n;
  assign snap_multi = (snap & (snap - 10'd1)) != 10'd0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    snap_n  = snap;
    data_n  = data;
    loadn_n = loadn;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    reject_n = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!inhibit && keys_s != 10'd0) begin
          snap_n  = keys_s;
          cnt_n   = CNT_ONE;
          state_n = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (keys_s != snap) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else if (cnt == DEB_LAST) begin
`ifdef KEYPAD_MULTIKEY_REJECT_EN
          if (snap_multi) begin
            reject_n = 1'b1;
            cnt_n    = '0;
            state_n  = ST_WAIT_RELEASE;
          end else begin
            data_n  = encode(snap);
            loadn_n = 1'b0;
            cnt_n   = CNT_ONE;
            state_n = ST_EMIT;
          end
`else
          data_n  = encode(snap);
          loadn_n = 1'b0;
          cnt_n   = CNT_ONE;
          state_n = ST_EMIT;
`endif
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      ST_EMIT: begin
        // cnt counts clocks with loadn low, including the edge it fell on
        if (cnt == LOAD_LAST) begin
          loadn_n = 1'b1;
          cnt_n   = '0;
          state_n = ST_WAIT_RELEASE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (keys_s != 10'd0) begin
          cnt_n = '0;
        end else if (cnt == DEB_LAST) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_n   = '0;
        loadn_n = 1'b1;
        state_n = ST_IDLE;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
      cnt   <= '0;
      snap  <= '0;
      data  <= 4'd0;
      loadn <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      snap  <= snap_n;
      data  <= data_n;
      loadn <= loadn_n;
      busy  <= busy_n;
    end
  end

`ifdef KEYPAD_MULTIKEY_REJECT_EN
  always_ff @(posedge clk) begin
    if (clr) reject <= 1'b0;
    else     reject <= reject_n;
  end
`else
  assign reject = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: directed scenarios plus random key
// traffic, all compared every cycle against a timestamp-based press model.
module tb_keypad_encoder;

  localparam int D = 4;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       clr;
  logic       inhibit;
  logic [9:0] keys;
  logic [3:0] data;
  logic       loadn;
  logic       busy;
  logic       reject;

  keypad_encoder #(.DEBOUNCE_CYCLES(D), .LOAD_CYCLES(L)) dut (
    .clk(clk), .clr(clr), .keys(keys), .inhibit(inhibit),
    .data(data), .loadn(loadn), .busy(busy), .reject(reject)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;
  int falls       = 0;
  int rejects     = 0;
  logic prev_loadn = 1'b1;

  // Model state: pressed key runs are tracked by start time, and the release
  // condition by the length of the current all-zero run of synchronised samples.
  bit         m_valid = 1'b0;
  bit         m_idle;
  bit         m_pending;
  int         cyc = 0;
  int         m_start;
  int         m_load_from;
  int         m_watch_from;
  int         m_zero_run;
  logic [9:0] m_s1, m_s2, m_snap, ks, lowest;
  bit         m_ok;
  logic [3:0] exp_data;
  bit         exp_loadn, exp_busy, exp_reject;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic [9:0] k, input logic inh, input logic c, input int n);
    @(negedge clk);
    keys    = k;
    inhibit = inh;
    clr     = c;
    repeat (n) @(posedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (clr) begin
      m_valid     = 1'b1;
      m_s1        = '0;
      m_s2        = '0;
      m_idle      = 1'b1;
      m_pending   = 1'b0;
      m_load_from = -100;
      m_watch_from = -100;
      m_zero_run  = 0;
      exp_data    = 4'd0;
      exp_reject  = 1'b0;
    end else if (m_valid) begin
      ks   = m_s2;
      m_s2 = m_s1;
      m_s1 = keys;
      m_zero_run = (ks == 10'd0) ? m_zero_run + 1 : 0;
      exp_reject = 1'b0;
      if (m_idle) begin
        if (!inhibit && ks != 10'd0) begin
          m_idle    = 1'b0;
          m_pending = 1'b1;
          m_snap    = ks;
          m_start   = cyc;
        end
      end else if (m_pending) begin
        if (ks != m_snap) begin
          m_idle    = 1'b1;
          m_pending = 1'b0;
        end else if (cyc - m_start + 1 == D) begin
          m_pending = 1'b0;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
          m_ok = ($countones(m_snap) == 1);
`else
          m_ok = 1'b1;
`endif
          if (m_ok) begin
            lowest       = m_snap & (~m_snap + 10'd1);
            exp_data     = 4'($clog2(lowest));
            m_load_from  = cyc;
            m_watch_from = cyc + L;
          end else begin
            exp_reject   = 1'b1;
            m_watch_from = cyc;
          end
        end
      end else if (m_zero_run >= D && cyc - m_watch_from >= D) begin
        m_idle = 1'b1;
      end
    end
    exp_loadn = !(cyc >= m_load_from && cyc < m_load_from + L);
    exp_busy  = !m_idle;
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      checkOutput("data",   32'(data),   32'(exp_data));
      checkOutput("loadn",  32'(loadn),  32'(exp_loadn));
      checkOutput("busy",   32'(busy),   32'(exp_busy));
      checkOutput("reject", 32'(reject), 32'(exp_reject));
      if (prev_loadn === 1'b1 && loadn === 1'b0) falls++;
      if (reject === 1'b1) rejects++;
      prev_loadn = loadn;
    end
  end

  initial begin
    int f0, r0, sel, n;
    logic [9:0] k;
    logic inh, c;
    keys = '0; inhibit = 1'b0; clr = 1'b1;

    // reset with a key already held, then one load of 2 after release
    applyStimulus(10'h004, 1'b0, 1'b1, 2);
    #1;
    checkOutput("reset_data", 32'(data), 0);
    checkOutput("reset_loadn", 32'(loadn), 1);
    checkOutput("reset_busy", 32'(busy), 0);
    f0 = falls;
    applyStimulus(10'h004, 1'b0, 1'b0, 12);
    #1;
    checkOutput("reset_load_data", 32'(data), 2);
    checkOutput("reset_load_count", falls - f0, 1);
    applyStimulus(10'h000, 1'b0, 1'b0, 8);

    // clean press of digit 8 with exact edge timing
    f0 = falls;
    applyStimulus(10'h100, 1'b0, 1'b0, 5);
    #1;
    checkOutput("press_pre_loadn", 32'(loadn), 1);
    checkOutput("press_pre_busy", 32'(busy), 1);
    applyStimulus(10'h100, 1'b0, 1'b0, 1);
    #1;
    checkOutput("press_fall_loadn", 32'(loadn), 0);
    checkOutput("press_fall_data", 32'(data), 8);
    applyStimulus(10'h100, 1'b0, 1'b0, 1);
    #1;
    checkOutput("press_low2_loadn", 32'(loadn), 0);
    applyStimulus(10'h100, 1'b0, 1'b0, 1);
    #1;
    checkOutput("press_rise_loadn", 32'(loadn), 1);
    applyStimulus(10'h100, 1'b0, 1'b0, 4);
    applyStimulus(10'h000, 1'b0, 1'b0, 5);
    #1;
    checkOutput("release_busy_hold", 32'(busy), 1);
    applyStimulus(10'h000, 1'b0, 1'b0, 1);
    #1;
    checkOutput("release_busy_fall", 32'(busy), 0);
    checkOutput("press_pulse_count", falls - f0, 1);
    checkOutput("press_data_hold", 32'(data), 8);

    // bounce: two-clock toggling never survives debounce
    f0 = falls;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(10'h002, 1'b0, 1'b0, 2);
      applyStimulus(10'h000, 1'b0, 1'b0, 2);
    end
    #1;
    checkOutput("bounce_no_pulse", falls - f0, 0);
    applyStimulus(10'h002, 1'b0, 1'b0, 12);
    #1;
    checkOutput("bounce_data", 32'(data), 1);
    checkOutput("bounce_one_pulse", falls - f0, 1);
    applyStimulus(10'h000, 1'b0, 1'b0, 8);

    // inhibit blocks a new press but not one already debouncing
    f0 = falls;
    applyStimulus(10'h020, 1'b1, 1'b0, 12);
    #1;
    checkOutput("inhibit_loadn", 32'(loadn), 1);
    checkOutput("inhibit_busy", 32'(busy), 0);
    checkOutput("inhibit_no_pulse", falls - f0, 0);
    applyStimulus(10'h000, 1'b1, 1'b0, 4);
    applyStimulus(10'h200, 1'b0, 1'b0, 3);
    applyStimulus(10'h200, 1'b1, 1'b0, 10);
    #1;
    checkOutput("inhibit_late_data", 32'(data), 9);
    checkOutput("inhibit_late_pulse", falls - f0, 1);
    applyStimulus(10'h000, 1'b0, 1'b0, 8);

    // two keys at once
    f0 = falls;
    r0 = rejects;
    applyStimulus(10'h088, 1'b0, 1'b0, 12);
    #1;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    checkOutput("multi_reject_count", rejects - r0, 1);
    checkOutput("multi_no_pulse", falls - f0, 0);
`else
    checkOutput("multi_data", 32'(data), 3);
    checkOutput("multi_pulse", falls - f0, 1);
    checkOutput("multi_no_reject", rejects - r0, 0);
`endif
    applyStimulus(10'h000, 1'b0, 1'b0, 8);

    // clear on the first EMIT clock
    applyStimulus(10'h010, 1'b0, 1'b0, 6);
    #1;
    checkOutput("clr_emit_loadn", 32'(loadn), 0);
    checkOutput("clr_emit_data", 32'(data), 4);
    applyStimulus(10'h010, 1'b0, 1'b1, 1);
    #1;
    checkOutput("clr_abort_loadn", 32'(loadn), 1);
    checkOutput("clr_abort_data", 32'(data), 0);
    checkOutput("clr_abort_busy", 32'(busy), 0);
    applyStimulus(10'h000, 1'b0, 1'b0, 3);
    #1;
    checkOutput("clr_idle_busy", 32'(busy), 0);

    // random key traffic against the model
    k = '0;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 2)      k = 10'd0;
      else if (sel <= 7) k = 10'd1 << $urandom_range(0, 9);
      else if (sel == 8) k = 10'($urandom);
      inh = ($urandom_range(0, 7) == 0);
      c   = ($urandom_range(0, 59) == 0);
      n   = $urandom_range(1, 14);
      applyStimulus(k, inh, c, n);
    end
    applyStimulus(10'h000, 1'b0, 1'b0, 12);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
